serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_adder_1bit.sv | 15 +
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and op select.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Carry/borrow seed for the LSB slice: subtraction adds ~b + 1.
    function automatic logic carry_seed(input logic op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_adder_adder_1bit.sv
// One-bit adder cell: propagate, generate and sum for a single bit slice.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic g,
    output logic s
);

    assign p = a ^ b;
    assign g = a & b;
    assign s = p ^ c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one adder cell per cycle, carry
// loop closed through a flop, result and flags written on the MSB slice.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             slice_p, slice_g, slice_s;
    logic             carry_next;
    logic [WIDTH-1:0] acc_shift;

    adder_1bit u_slice (
        .a (ra_q[0]),
        .b (rb_q[0]),
        .c (c_q),
        .p (slice_p),
        .g (slice_g),
        .s (slice_s)
    );

    assign carry_next = slice_g | (slice_p & c_q);
    assign acc_shift  = {slice_s, acc_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    ra_d    = a;
                    rb_d    = b ^ {WIDTH{sub}};
                    c_d     = carry_seed(sub);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                acc_d = acc_shift;
                c_d   = carry_next;
                cnt_d = cnt_q + CW'(1);
                // MSB slice: c_q is the carry into the MSB, carry_next the carry out.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_shift;
                    cout_d  = carry_next;
                    ovf_d   = c_q ^ carry_next;
                    zero_d  = (acc_shift == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath shift registers are reset too, so an aborted operation leaves
    // no stale operand bits behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, busy, done;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int dones = 0;
    res_t exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        res_t r;
        int ux, uy, sx, sy, ru, rs;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ru = s ? ux - uy : ux + uy;
        rs = s ? sx - sy : sx + sy;
        r.sum  = ru[W-1:0];
        r.cout = s ? (ux >= uy) : (ru > 65535);
        r.ovf  = (rs > 32767) || (rs < -32768);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) check("busy_and_done", 32'd1, 32'd0);
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("zero", 32'(zero), 32'(e.zero));
                end
            end
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("wait_not_busy_timeout", 32'd1, 32'd0);
    endtask

    // Returns 1 ns after the accepting edge with start deasserted.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input res_t e);
        wait_not_busy();
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        exp_q.push_back(e);
        starts++;
        @(posedge clk); #1;
        start = 1'b0;
        check("accepted_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("wait_done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_cnt, done_before;
        logic [W-1:0] ra, rb;
        logic rs;

        // Reset state.
        #12;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", {28'd0, cout, ovf, zero, 1'b0}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and busy duration.
        issue(16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0));
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_cnt++;
        end
        check("latency", 32'(n), 32'd16);
        check("busy_cycles", 32'(busy_cnt), 32'd16);

        // Carry/overflow/borrow corners.
        issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        issue(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        issue(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));

        // Start held through RUN and DONE: second op follows with no bubble.
        wait_not_busy();
        a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;
        exp_q.push_back(mk(16'h0007, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
        starts += 2;
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555;
        wait_done(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_no_bubble", 32'(busy), 32'd1);
        wait_done(n);
        @(posedge clk); #1;

        // Asynchronous reset mid-operation.
        issue(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        void'(exp_q.pop_back());
        starts--;
        #1;
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        check("arst_busy_done", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        done_before = dones;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(dones), 32'(done_before));
        issue(16'h0F0F, 16'h0101, 1'b1, mk(16'h0E0E, 1'b1, 1'b0, 1'b0));

        // Random ops with random gaps (gap 0 exercises start in DONE).
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: ra = 16'h7FFF;
                2: ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            wait_not_busy();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            issue(ra, rb, rs, model(ra, rb, rs));
        end
        wait_done(n);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'(starts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
